// File: rtl/excp_ctrl_pkg.sv
// Shared constants, state encoding and cause classification for the
// machine-mode trap/return sequencer.
package excp_ctrl_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [3:0] EXCP_CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXCP_CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] EXCP_CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXCP_CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXCP_CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXCP_CAUSE_ECALL_M        = 4'd11;

  localparam int EXCP_NUM_FLAGS            = 6;
  localparam int EXCP_FLAG_INSTR_MISALIGN  = 0;
  localparam int EXCP_FLAG_ILLEGAL         = 1;
  localparam int EXCP_FLAG_EBREAK          = 2;
  localparam int EXCP_FLAG_ECALL           = 3;
  localparam int EXCP_FLAG_LOAD_MISALIGN   = 4;
  localparam int EXCP_FLAG_STORE_MISALIGN  = 5;

  typedef enum logic [1:0] {
    EXCP_ST_IDLE  = 2'd0,
    EXCP_ST_TRAP  = 2'd1,
    EXCP_ST_REDIR = 2'd2,
    EXCP_ST_RET   = 2'd3
  } excp_state_e;

  typedef enum logic [1:0] {
    TVAL_ZERO    = 2'd0,
    TVAL_BADADDR = 2'd1,
    TVAL_INST    = 2'd2
  } excp_tval_src_e;

  typedef struct packed {
    logic [3:0]     code;
    excp_tval_src_e tval_src;
  } excp_cause_t;

  // Lowest flag index has highest priority; an empty flag set yields cause 0 / zero tval.
  function automatic excp_cause_t excp_classify(input logic [EXCP_NUM_FLAGS-1:0] flags);
    excp_cause_t r;
    r.code     = EXCP_CAUSE_INSTR_MISALIGN;
    r.tval_src = TVAL_ZERO;
    if (flags[EXCP_FLAG_INSTR_MISALIGN]) begin
      r.code     = EXCP_CAUSE_INSTR_MISALIGN;
      r.tval_src = TVAL_BADADDR;
    end else if (flags[EXCP_FLAG_ILLEGAL]) begin
      r.code     = EXCP_CAUSE_ILLEGAL;
      r.tval_src = TVAL_INST;
    end else if (flags[EXCP_FLAG_EBREAK]) begin
      r.code     = EXCP_CAUSE_BREAKPOINT;
      r.tval_src = TVAL_ZERO;
    end else if (flags[EXCP_FLAG_ECALL]) begin
      r.code     = EXCP_CAUSE_ECALL_M;
      r.tval_src = TVAL_ZERO;
    end else if (flags[EXCP_FLAG_LOAD_MISALIGN]) begin
      r.code     = EXCP_CAUSE_LOAD_MISALIGN;
      r.tval_src = TVAL_BADADDR;
    end else if (flags[EXCP_FLAG_STORE_MISALIGN]) begin
      r.code     = EXCP_CAUSE_STORE_MISALIGN;
      r.tval_src = TVAL_BADADDR;
    end
    return r;
  endfunction

endpackage

// File: rtl/excp_ctrl_prio_enc.sv
// Combinational priority encoder from WB exception flags to the
// {mcause, mtval} pair written on trap entry.
module excp_prio_enc
  import excp_ctrl_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [EXCP_NUM_FLAGS-1:0] wb_excp_i,
  input  logic [31:0]               wb_inst_i,
  input  logic [XLEN-1:0]           wb_badaddr_i,
  output logic [XLEN-1:0]           cause_o,
  output logic [XLEN-1:0]           tval_o
);

  excp_cause_t cls;

  always_comb begin
    cls     = excp_classify(wb_excp_i);
    cause_o = XLEN'(cls.code);
    tval_o  = '0;
    case (cls.tval_src)
      TVAL_BADADDR: tval_o = wb_badaddr_i;
      TVAL_INST:    tval_o = XLEN'(wb_inst_i);
      default:      tval_o = '0;
    endcase
  end

endmodule

// File: rtl/excp_ctrl.sv
// Trap and MRET sequencer: writes mcause/mtval/mepc on a WB exception,
// then holds a redirect request to fetch while the pipeline is flushed.
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int              XLEN   = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RST_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid_i,
  input  logic [XLEN-1:0]           wb_pc_i,
  input  logic [31:0]               wb_inst_i,
  input  logic [EXCP_NUM_FLAGS-1:0] wb_excp_i,
  input  logic [XLEN-1:0]           wb_badaddr_i,
  input  logic                      wb_mret_i,
  output logic                      wb_csr_kill_o,
  output logic                      mcause_wen_o,
  output logic [XLEN-1:0]           mcause_wdata_o,
  output logic                      mtval_wen_o,
  output logic [XLEN-1:0]           mtval_wdata_o,
  output logic                      mepc_wen_o,
  output logic [XLEN-1:0]           mepc_wdata_o,
  input  logic [XLEN-1:0]           mtvec_rdata_i,
  input  logic [XLEN-1:0]           mepc_rdata_i,
  output logic                      flush_o,
  output logic                      redirect_valid_o,
  output logic [XLEN-1:0]           redirect_pc_o,
  input  logic                      redirect_ready_i,
  output logic [31:0]               trap_cnt_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  excp_state_e     state;
  logic [XLEN-1:0] enc_cause;
  logic [XLEN-1:0] enc_tval;
  logic            take_trap;
  logic            take_ret;

  excp_prio_enc #(
    .XLEN (XLEN)
  ) u_prio_enc (
    .wb_excp_i    (wb_excp_i),
    .wb_inst_i    (wb_inst_i),
    .wb_badaddr_i (wb_badaddr_i),
    .cause_o      (enc_cause),
    .tval_o       (enc_tval)
  );

  // An exception always beats a simultaneous MRET.
  assign take_trap     = (state == EXCP_ST_IDLE) && wb_valid_i && (|wb_excp_i);
  assign take_ret      = (state == EXCP_ST_IDLE) && wb_valid_i && !(|wb_excp_i) && wb_mret_i;
  assign wb_csr_kill_o = take_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= EXCP_ST_IDLE;
      mcause_wen_o     <= 1'b0;
      mtval_wen_o      <= 1'b0;
      mepc_wen_o       <= 1'b0;
      mcause_wdata_o   <= '0;
      mtval_wdata_o    <= '0;
      mepc_wdata_o     <= '0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= RST_PC;
      trap_cnt_o       <= '0;
    end else begin
      mcause_wen_o <= 1'b0;
      mtval_wen_o  <= 1'b0;
      mepc_wen_o   <= 1'b0;
      case (state)
        EXCP_ST_IDLE: begin
          if (take_trap) begin
            state          <= EXCP_ST_TRAP;
            mcause_wen_o   <= 1'b1;
            mtval_wen_o    <= 1'b1;
            mepc_wen_o     <= 1'b1;
            mcause_wdata_o <= enc_cause;
            mtval_wdata_o  <= enc_tval;
            mepc_wdata_o   <= wb_pc_i & ALIGN_MASK;
            flush_o        <= 1'b1;
          end else if (take_ret) begin
            state            <= EXCP_ST_RET;
            flush_o          <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= mepc_rdata_i & ALIGN_MASK;
          end
        end
        // mtvec is sampled here so a CSR write landing this edge is not seen; direct mode only.
        EXCP_ST_TRAP: begin
          state            <= EXCP_ST_REDIR;
          trap_cnt_o       <= trap_cnt_o + 32'd1;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= mtvec_rdata_i & ALIGN_MASK;
        end
        EXCP_ST_REDIR, EXCP_ST_RET: begin
          if (redirect_ready_i) begin
            state            <= EXCP_ST_IDLE;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
          end
        end
        default: begin
          state            <= EXCP_ST_IDLE;
          flush_o          <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: directed trap/MRET cases plus random
// transactions checked against a per-transaction timeline model.
module tb_excp_ctrl;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk;
  logic        rst;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic [31:0] wb_inst_i;
  logic [5:0]  wb_excp_i;
  logic [31:0] wb_badaddr_i;
  logic        wb_mret_i;
  logic        wb_csr_kill_o;
  logic        mcause_wen_o;
  logic [31:0] mcause_wdata_o;
  logic        mtval_wen_o;
  logic [31:0] mtval_wdata_o;
  logic        mepc_wen_o;
  logic [31:0] mepc_wdata_o;
  logic [31:0] mtvec_rdata_i;
  logic [31:0] mepc_rdata_i;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic [31:0] trap_cnt_o;

  int          checks;
  int          fails;
  int unsigned model_cnt;

  excp_ctrl #(
    .XLEN   (XLEN),
    .RST_PC (RST_PC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid_i       (wb_valid_i),
    .wb_pc_i          (wb_pc_i),
    .wb_inst_i        (wb_inst_i),
    .wb_excp_i        (wb_excp_i),
    .wb_badaddr_i     (wb_badaddr_i),
    .wb_mret_i        (wb_mret_i),
    .wb_csr_kill_o    (wb_csr_kill_o),
    .mcause_wen_o     (mcause_wen_o),
    .mcause_wdata_o   (mcause_wdata_o),
    .mtval_wen_o      (mtval_wen_o),
    .mtval_wdata_o    (mtval_wdata_o),
    .mepc_wen_o       (mepc_wen_o),
    .mepc_wdata_o     (mepc_wdata_o),
    .mtvec_rdata_i    (mtvec_rdata_i),
    .mepc_rdata_i     (mepc_rdata_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .trap_cnt_o       (trap_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference: flag bits are listed in priority order; table gives cause and tval kind.
  function automatic void modelTrap(input logic [5:0] flags, input logic [31:0] inst,
                                    input logic [31:0] badaddr,
                                    output logic [31:0] cause, output logic [31:0] tval);
    int unsigned cause_tab[6] = '{0, 2, 3, 11, 4, 6};
    int          tval_kind[6] = '{1, 2, 0, 0, 1, 1};
    cause = 32'd0;
    tval  = 32'd0;
    for (int i = 5; i >= 0; i--) begin
      if (flags[i]) begin
        cause = cause_tab[i];
        tval  = (tval_kind[i] == 1) ? badaddr : (tval_kind[i] == 2) ? inst : 32'd0;
      end
    end
  endfunction

  task automatic driveIdle();
    wb_valid_i       = 1'b0;
    wb_excp_i        = 6'd0;
    wb_mret_i        = 1'b0;
    redirect_ready_i = 1'($urandom);
  endtask

  task automatic driveJunk(input bit keep_mtvec);
    wb_valid_i   = 1'b1;
    wb_excp_i    = 6'($urandom_range(1, 63));
    wb_mret_i    = 1'($urandom);
    wb_pc_i      = $urandom;
    wb_inst_i    = $urandom;
    wb_badaddr_i = $urandom;
    mepc_rdata_i = $urandom;
    if (!keep_mtvec) mtvec_rdata_i = $urandom;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_flush"}, 64'(flush_o), 64'd0);
    checkOutput({tag, "_rvalid"}, 64'(redirect_valid_o), 64'd0);
    checkOutput({tag, "_wen"}, 64'({mcause_wen_o, mtval_wen_o, mepc_wen_o}), 64'd0);
    checkOutput({tag, "_cnt"}, 64'(trap_cnt_o), 64'(model_cnt));
  endtask

  // One WB transaction starting from IDLE; delay = redirect cycles with ready low.
  task automatic applyStimulus(input bit valid, input logic [5:0] flags, input bit mret,
                               input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] badaddr, input logic [31:0] mtvec,
                               input logic [31:0] mepc, input int delay);
    bit          is_trap;
    bit          is_ret;
    logic [31:0] exp_cause;
    logic [31:0] exp_tval;
    logic [31:0] exp_pc;
    is_trap = valid && (flags != 6'd0);
    is_ret  = valid && (flags == 6'd0) && mret;
    modelTrap(flags, inst, badaddr, exp_cause, exp_tval);
    exp_pc  = is_trap ? {mtvec[31:2], 2'b00} : {mepc[31:2], 2'b00};

    @(posedge clk); #1;
    wb_valid_i = valid; wb_excp_i = flags; wb_mret_i = mret; wb_pc_i = pc;
    wb_inst_i = inst; wb_badaddr_i = badaddr; mtvec_rdata_i = mtvec; mepc_rdata_i = mepc;
    redirect_ready_i = 1'($urandom);
    #1;
    checkOutput("kill_T", 64'(wb_csr_kill_o), 64'(is_trap));
    checkQuiet("idle_T");

    if (is_trap) begin
      @(posedge clk); #1;
      driveJunk(1'b1);
      redirect_ready_i = 1'($urandom);
      #1;
      checkOutput("trap_wen", 64'({mcause_wen_o, mtval_wen_o, mepc_wen_o}), 64'h7);
      checkOutput("mcause", 64'(mcause_wdata_o), 64'(exp_cause));
      checkOutput("mtval", 64'(mtval_wdata_o), 64'(exp_tval));
      checkOutput("mepc", 64'(mepc_wdata_o), 64'({pc[31:2], 2'b00}));
      checkOutput("trap_flush", 64'(flush_o), 64'd1);
      checkOutput("trap_rvalid", 64'(redirect_valid_o), 64'd0);
      checkOutput("trap_kill", 64'(wb_csr_kill_o), 64'd0);
      model_cnt++;
    end

    if (is_trap || is_ret) begin
      for (int k = 0; k <= delay; k++) begin
        @(posedge clk); #1;
        driveJunk(1'b0);
        redirect_ready_i = (k == delay);
        #1;
        checkOutput("redir_valid", 64'(redirect_valid_o), 64'd1);
        checkOutput("redir_pc", 64'(redirect_pc_o), 64'(exp_pc));
        checkOutput("redir_flush", 64'(flush_o), 64'd1);
        checkOutput("redir_wen", 64'({mcause_wen_o, mtval_wen_o, mepc_wen_o}), 64'd0);
        checkOutput("redir_kill", 64'(wb_csr_kill_o), 64'd0);
        checkOutput("redir_cnt", 64'(trap_cnt_o), 64'(model_cnt));
      end
    end

    @(posedge clk); #1;
    driveIdle();
    #1;
    checkQuiet("back_idle");
  endtask

  task automatic applyReset();
    rst = 1'b1;
    driveIdle();
    repeat (2) @(posedge clk);
    #2;
    model_cnt = 0;
    checkOutput("rst_pc", 64'(redirect_pc_o), 64'(RST_PC));
    checkQuiet("rst");
    checkOutput("rst_wdata", 64'({mcause_wdata_o, mtval_wdata_o}) | 64'(mepc_wdata_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic resetDuringTrap();
    @(posedge clk); #1;
    wb_valid_i = 1'b1; wb_excp_i = 6'b000010; wb_mret_i = 1'b0;
    wb_pc_i = 32'h300; wb_inst_i = 32'hDEAD_BEEF; mtvec_rdata_i = 32'h0000_0A00;
    #1;
    checkOutput("ar_kill", 64'(wb_csr_kill_o), 64'd1);
    @(posedge clk); #1;
    driveIdle();
    #1;
    checkOutput("ar_wen_before", 64'({mcause_wen_o, mtval_wen_o, mepc_wen_o}), 64'h7);
    #2 rst = 1'b1;
    #1;
    model_cnt = 0;
    checkOutput("ar_wen_after", 64'({mcause_wen_o, mtval_wen_o, mepc_wen_o}), 64'd0);
    checkOutput("ar_pc", 64'(redirect_pc_o), 64'(RST_PC));
    checkQuiet("ar");
    #2 rst = 1'b0;
    @(posedge clk); #2;
    checkQuiet("ar_stay_idle");
  endtask

  initial begin
    checks = 0;
    fails = 0;
    model_cnt = 0;
    wb_pc_i = '0; wb_inst_i = '0; wb_badaddr_i = '0;
    mtvec_rdata_i = '0; mepc_rdata_i = '0;
    applyReset();

    applyStimulus(1'b1, 6'b000010, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h800, 32'h0, 0);
    applyStimulus(1'b1, 6'b110001, 1'b0, 32'h204, 32'h13, 32'h203, 32'h803, 32'h0, 1);
    applyStimulus(1'b1, 6'b001000, 1'b1, 32'h40A, 32'h73, 32'h0, 32'h900, 32'h5550, 0);
    applyStimulus(1'b1, 6'b000000, 1'b1, 32'h500, 32'h3020_0073, 32'h0, 32'h900, 32'h1234, 3);
    applyStimulus(1'b1, 6'b010100, 1'b0, 32'h600, 32'h0010_0073, 32'h7, 32'h904, 32'h0, 2);
    applyStimulus(1'b0, 6'b000100, 1'b1, 32'h700, 32'h0, 32'h0, 32'h904, 32'h88, 0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] flags;
      flags = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      applyStimulus(($urandom_range(0, 4) != 0), flags, 1'($urandom), $urandom, $urandom,
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    resetDuringTrap();
    applyStimulus(1'b1, 6'b100000, 1'b0, 32'h104, 32'h0, 32'h105, 32'hC00, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Trap and return sequencer between the WB stage and the machine-mode CSR file.
- Detects a synchronous exception or an MRET on the retiring instruction.
- Produces the mcause/mtval/mepc write strobes the CSR file consumes.
- Reads back mtvec/mepc and drives a held redirect request to fetch while flushing the pipeline.

## Interface
Parameters:
- XLEN, default `XLEN, datapath width.
- RST_PC, default 0, redirect_pc_o value at reset.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  async reset, active high
- wb_valid_i  in  1  WB holds a retiring instruction
- wb_pc_i  in  XLEN  PC of WB instruction
- wb_inst_i  in  32  instruction bits
- wb_excp_i  in  6  flags: [0] instr misaligned, [1] illegal, [2] ebreak, [3] ecall, [4] load misaligned, [5] store misaligned
- wb_badaddr_i  in  XLEN  faulting address for misaligned cases
- wb_mret_i  in  1  WB instruction is MRET
- wb_csr_kill_o  out  1  suppress the WB CSR/regfile write of the current instruction
- mcause_wen_o / mcause_wdata_o  out  1 / XLEN  write port to mcause
- mtval_wen_o / mtval_wdata_o  out  1 / XLEN  write port to mtval
- mepc_wen_o / mepc_wdata_o  out  1 / XLEN  write port to mepc
- mtvec_rdata_i  in  XLEN  current mtvec
- mepc_rdata_i  in  XLEN  current mepc
- flush_o  out  1  squash all stages IF..WB
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  XLEN  redirect target
- redirect_ready_i  in  1  fetch accepts redirect
- trap_cnt_o  out  32  count of traps taken, wraps

## Operation
States are IDLE, TRAP, REDIR and RET.
- IDLE:
  - wb_valid_i & |wb_excp_i: latch cause/tval/pc and go to TRAP. Exception wins over a simultaneous wb_mret_i.
  - wb_valid_i & wb_mret_i with no exception: go to RET.
  - wb_csr_kill_o is combinational, = wb_valid_i & |wb_excp_i while in IDLE.
- TRAP, exactly one cycle:
  - mcause_wen_o = mtval_wen_o = mepc_wen_o = 1, with the latched values.
  - trap_cnt_o increments by 1 at exit, wrapping at 2^32-1 -> 0.
  - Next state is REDIR.
- REDIR:
  - redirect_valid_o = 1 and redirect_pc_o = {mtvec_rdata_i[XLEN-1:2], 2'b00} (direct mode only).
  - Held until redirect_ready_i = 1, then go to IDLE.
- RET:
  - redirect_valid_o = 1 and redirect_pc_o = {mepc_rdata_i[XLEN-1:2], 2'b00}.
  - Held until redirect_ready_i, then go to IDLE.
- Cause priority and values, handled by the encoder:
  - instr misaligned: cause 0, tval = badaddr.
  - illegal: cause 2, tval = wb_inst_i zero-extended.
  - ebreak: cause 3, tval 0.
  - ecall: cause 11, tval 0.
  - load misaligned: cause 4, tval = badaddr.
  - store misaligned: cause 6, tval = badaddr.
- mepc_wdata = {wb_pc_i[XLEN-1:2], 2'b00}.
- flush_o = 1 in every state except IDLE.
- WB inputs are ignored outside IDLE. The pipeline is already flushed, so no nested trap is possible.

## Timing
- Reset values:
  - state IDLE.
  - All wen outputs 0, all wdata 0.
  - flush_o 0, redirect_valid_o 0, redirect_pc_o RST_PC, trap_cnt_o 0.
- Trap sequence:
  - Exception seen in WB at cycle T.
  - CSR wen high in cycle T+1; CSR updates at the T+2 edge.
  - redirect_valid_o first high in T+2.
  - Minimum trap-to-IDLE is 3 cycles when ready is already high.
- MRET: redirect_valid_o high in T+1; return to IDLE at the first edge with redirect_ready_i.
- Redirect handshake: redirect_valid_o, once raised, stays high with a stable redirect_pc_o until accepted. redirect_pc_o is registered on state entry.
- Reset mid-sequence: immediate return to IDLE and all outputs to reset values. No partial CSR write survives, because wen drops asynchronously.

## Structure
- Shared defines header, extended alongside `XLEN/`CSR_*:
  - `EXCP_CAUSE_* constants (0, 2, 3, 4, 6, 11).
  - 2-bit state encoding `EXCP_ST_IDLE/TRAP/REDIR/RET.
  - Flag bit indices.
- One sub-module, excp_prio_enc: combinational priority encoder from wb_excp_i/wb_inst_i/wb_badaddr_i to {cause, tval}.
- FSM, latches, redirect register and counter live in excp_ctrl.

## Test plan
- Illegal instruction:
  - Stimulus: wb_pc=0x100, inst=0xFFFFFFFF, flags=6'b000010, mtvec=0x800, ready=1.
  - Response: T+1 mcause=2, mtval=0xFFFFFFFF, mepc=0x100 with all wens high; T+2 redirect 0x800; trap_cnt=1; flush high T+1..T+2.
- Multiple flags:
  - Stimulus: flags=6'b110001, badaddr=0x203.
  - Response: mcause=0, mtval=0x203.
- Exception plus MRET:
  - Stimulus: ecall and wb_mret together.
  - Response: mcause=11, redirect to mtvec; RET never entered.
- MRET:
  - Stimulus: mepc_rdata=0x1234, ready low 3 cycles.
  - Response: redirect_valid high for 4 cycles with pc 0x1234, then IDLE; no wen pulses.
- Ignored input and kill:
  - Stimulus: second exception on wb inputs during REDIR.
  - Response: ignored; trap_cnt unchanged. wb_csr_kill_o high only in cycle T.
- Async reset:
  - Stimulus: assert rst during TRAP.
  - Response: wens drop the same cycle without a clock edge; state IDLE; trap_cnt=0; redirect_pc=RST_PC.
